// File: rtl/data_cache_sync.sv
// data_cache_sync: direct-mapped, write-allocate / write-through L1 data cache.
// Serves 32-bit little-endian accesses at any byte alignment, including ones that
// straddle two lines (and the top-of-memory wrap), refilling whole lines over a
// req/ack handshake. A full invalidate walk runs out of reset and on flush.
module data_cache_sync #(
  parameter int LINE_BYTES = 64,
  parameter int NUM_LINES  = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_be,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_ack,
  input  logic [LINE_BYTES*8-1:0] mem_line,
  output logic                    mem_wr_req,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [31:0]             mem_wr_data,
  output logic [3:0]              mem_wr_be,
  input  logic                    mem_wr_ack,
  input  logic                    flush,
  output logic                    flush_done
);

  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int LOW_W    = OFFSET_W + INDEX_W;
  localparam int LINE_W   = LINE_BYTES * 8;
  localparam int LADDR_W  = ADDR_WIDTH - OFFSET_W;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t               state_reg;
  logic [INDEX_W-1:0]   flush_cnt_reg;

  // Cache storage; valid bits are cleared by the invalidate walk, never by reset.
  logic                 valid_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem   [NUM_LINES];
  logic [LINE_W-1:0]    data_mem  [NUM_LINES];

  // Per-byte location of addr+k. Index/offset only depend on the low address
  // bits, so the sum is done modulo the index+offset space.
  logic [LOW_W-1:0]     byte_low [4];
  logic [INDEX_W-1:0]   byte_idx [4];
  logic [OFFSET_W-1:0]  byte_off [4];
  logic [7:0]           byte_rd  [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_low[gi] = cpu_addr[LOW_W-1:0] + LOW_W'(gi);
      assign byte_idx[gi] = byte_low[gi][LOW_W-1:OFFSET_W];
      assign byte_off[gi] = byte_low[gi][OFFSET_W-1:0];
      assign byte_rd[gi]  = data_mem[byte_idx[gi]][{byte_off[gi], 3'b000} +: 8];
    end
  endgenerate

  // Line numbers of the first and last byte; they differ only when the access
  // crosses a line boundary, and the increment wraps at the top of memory.
  logic [LADDR_W-1:0]   lo_line;
  logic [LADDR_W-1:0]   hi_line;
  logic                 spans;
  logic                 lo_hit;
  logic                 hi_hit;
  logic                 hit;
  logic [ADDR_WIDTH-1:0] refill_addr;
  logic                 write_hit;

  assign lo_line = cpu_addr[ADDR_WIDTH-1:OFFSET_W];
  assign spans   = cpu_addr[OFFSET_W-1:0] > OFFSET_W'(LINE_BYTES - 4);
  assign hi_line = lo_line + LADDR_W'(spans);

  assign lo_hit = valid_mem[byte_idx[0]] && (tag_mem[byte_idx[0]] == lo_line[LADDR_W-1:INDEX_W]);
  assign hi_hit = valid_mem[byte_idx[3]] && (tag_mem[byte_idx[3]] == hi_line[LADDR_W-1:INDEX_W]);
  assign hit    = lo_hit && hi_hit;

  // Refill the low line first; the high line is fetched on the next lookup.
  assign refill_addr = lo_hit ? {hi_line, {OFFSET_W{1'b0}}} : {lo_line, {OFFSET_W{1'b0}}};

  assign write_hit = (state_reg == ST_IDLE) && !flush && cpu_req && cpu_we && hit;

  // Control FSM with registered handshake and data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_FLUSH;
      flush_cnt_reg <= '0;
      cpu_rdata     <= '0;
      cpu_ready     <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wr_req    <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      mem_wr_be     <= '0;
      flush_done    <= 1'b0;
    end else begin
      cpu_ready  <= 1'b0;
      flush_done <= 1'b0;
      case (state_reg)
        ST_FLUSH: begin
          if (flush_cnt_reg == INDEX_W'(NUM_LINES - 1)) begin
            flush_done <= 1'b1;
            state_reg  <= ST_IDLE;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + INDEX_W'(1);
          end
        end
        ST_IDLE: begin
          if (flush) begin
            flush_cnt_reg <= '0;
            state_reg     <= ST_FLUSH;
          end else if (cpu_req) begin
            if (!hit) begin
              mem_req   <= 1'b1;
              mem_addr  <= refill_addr;
              state_reg <= ST_REFILL;
            end else if (cpu_we) begin
              mem_wr_req  <= 1'b1;
              mem_wr_addr <= cpu_addr;
              mem_wr_data <= cpu_wdata;
              mem_wr_be   <= cpu_be;
              state_reg   <= ST_WRITE;
            end else begin
              cpu_rdata <= {byte_rd[3], byte_rd[2], byte_rd[1], byte_rd[0]};
              cpu_ready <= 1'b1;
              state_reg <= ST_RESP;
            end
          end
        end
        ST_REFILL: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (mem_wr_ack) begin
            mem_wr_req <= 1'b0;
            cpu_ready  <= 1'b1;
            state_reg  <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_FLUSH;
        end
      endcase
    end
  end

  // Array updates: invalidate walk, line install on refill ack, byte merge on store hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == ST_FLUSH) begin
        valid_mem[flush_cnt_reg] <= 1'b0;
      end
      if ((state_reg == ST_REFILL) && mem_ack) begin
        valid_mem[mem_addr[LOW_W-1:OFFSET_W]] <= 1'b1;
        tag_mem[mem_addr[LOW_W-1:OFFSET_W]]   <= mem_addr[ADDR_WIDTH-1:LOW_W];
        data_mem[mem_addr[LOW_W-1:OFFSET_W]]  <= mem_line;
      end
      if (write_hit) begin
        for (int k = 0; k < 4; k++) begin
          if (cpu_be[k]) begin
            data_mem[byte_idx[k]][{byte_off[k], 3'b000} +: 8] <= cpu_wdata[8*k +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_cache_sync.sv
// tb_data_cache_sync: directed vectors with hand-computed expectations for data_cache_sync.
// Memory model: byte j of the line at base B is B[7:0] + j + (B[14:12]-1)*16 (mod 256),
// so line 0x1000 holds byte j = j.
module tb_data_cache_sync;
  localparam int LINE_BYTES = 64;
  localparam int NUM_LINES  = 256;
  localparam int ADDR_WIDTH = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cpu_req;
  logic                    cpu_we;
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic [31:0]             cpu_wdata;
  logic [3:0]              cpu_be;
  logic [31:0]             cpu_rdata;
  logic                    cpu_ready;
  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_ack;
  logic [LINE_BYTES*8-1:0] mem_line;
  logic                    mem_wr_req;
  logic [ADDR_WIDTH-1:0]   mem_wr_addr;
  logic [31:0]             mem_wr_data;
  logic [3:0]              mem_wr_be;
  logic                    mem_wr_ack;
  logic                    flush;
  logic                    flush_done;

  always #5 clk = ~clk;

  data_cache_sync #(
    .LINE_BYTES (LINE_BYTES),
    .NUM_LINES  (NUM_LINES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_be      (cpu_be),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_line    (mem_line),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_be   (mem_wr_be),
    .mem_wr_ack  (mem_wr_ack),
    .flush       (flush),
    .flush_done  (flush_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] refill_q [$];
  logic [31:0] wr_addr_seen;
  logic [31:0] wr_data_seen;
  logic [3:0]  wr_be_seen;

  function automatic logic [LINE_BYTES*8-1:0] line_of(input logic [31:0] base);
    logic [LINE_BYTES*8-1:0] l;
    int v;
    l = '0;
    for (int j = 0; j < LINE_BYTES; j++) begin
      v = int'(base[7:0]) + j + (int'(base[14:12]) - 1) * 16;
      l[8*j +: 8] = 8'(v);
    end
    return l;
  endfunction

  function automatic logic [31:0] refill_at(input int i);
    return (refill_q.size() > i) ? refill_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Services refill / write-through handshakes until cpu_ready (bounded).
  task automatic run_access(output logic [31:0] rdata, output int refills,
                            output int writes, output int cycles);
    bit done;
    done    = 1'b0;
    rdata   = '0;
    refills = 0;
    writes  = 0;
    cycles  = 0;
    refill_q.delete();
    while (!done && cycles < 60) begin
      @(negedge clk);
      cycles++;
      mem_ack    = 1'b0;
      mem_wr_ack = 1'b0;
      if (cpu_ready) begin
        rdata = cpu_rdata;
        done  = 1'b1;
      end else if (mem_req) begin
        refill_q.push_back(mem_addr);
        mem_line = line_of(mem_addr);
        mem_ack  = 1'b1;
        refills++;
      end else if (mem_wr_req) begin
        wr_addr_seen = mem_wr_addr;
        wr_data_seen = mem_wr_data;
        wr_be_seen   = mem_wr_be;
        mem_wr_ack   = 1'b1;
        writes++;
      end
    end
    cpu_req    = 1'b0;
    mem_ack    = 1'b0;
    mem_wr_ack = 1'b0;
    check_val("access_completes", 64'(done), 64'(1));
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata,
                        output int refills, output int writes, output int cycles);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_be    = be;
    run_access(rdata, refills, writes, cycles);
    $display("%s addr=%h wdata=%h be=%b -> rdata=%h refills=%0d writes=%0d cycles=%0d",
             we ? "ST" : "LD", addr, wdata, be, rdata, refills, writes, cycles);
  endtask

  task automatic wait_flush_done(output int n, output bit seen, output bit saw_ready,
                                 output bit saw_req);
    n = 0; seen = 1'b0; saw_ready = 1'b0; saw_req = 1'b0;
    while (!seen && n < NUM_LINES + 10) begin
      @(negedge clk);
      n++;
      if (cpu_ready) saw_ready = 1'b1;
      if (mem_req) saw_req = 1'b1;
      if (flush_done) seen = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int refills, writes, cycles, n;
    bit seen, saw_ready, saw_req;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    mem_ack = 1'b0; mem_line = '0; mem_wr_ack = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check_val("rst_cpu_ready", 64'(cpu_ready), 64'(0));
    check_val("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    check_val("rst_mem_req", 64'(mem_req), 64'(0));
    check_val("rst_mem_addr", 64'(mem_addr), 64'(0));
    check_val("rst_mem_wr_req", 64'(mem_wr_req), 64'(0));
    check_val("rst_mem_wr_addr", 64'(mem_wr_addr), 64'(0));
    check_val("rst_mem_wr_data", 64'(mem_wr_data), 64'(0));
    check_val("rst_mem_wr_be", 64'(mem_wr_be), 64'(0));
    check_val("rst_flush_done", 64'(flush_done), 64'(0));

    // Reset walk: flush_done NUM_LINES edges after release (NUM_LINES+1 counting the
    // reset cycle); a request held during the walk is ignored.
    rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000;
    wait_flush_done(n, seen, saw_ready, saw_req);
    cpu_req = 1'b0;
    $display("reset walk: flush_done after %0d cycles", n);
    check_val("rstwalk_done_seen", 64'(seen), 64'(1));
    check_val("rstwalk_cycles", 64'(n), 64'(NUM_LINES));
    check_val("rstwalk_no_ready", 64'(saw_ready), 64'(0));
    check_val("rstwalk_no_mem_req", 64'(saw_req), 64'(0));

    // Cold load then reload hit
    access(1'b0, 32'h1000, '0, '0, rd, refills, writes, cycles);
    check_val("cold_rdata", 64'(rd), 64'h0302_0100);
    check_val("cold_refills", 64'(refills), 64'(1));
    check_val("cold_refill_addr", 64'(refill_at(0)), 64'h1000);
    access(1'b0, 32'h1000, '0, '0, rd, refills, writes, cycles);
    check_val("hit_rdata", 64'(rd), 64'h0302_0100);
    check_val("hit_refills", 64'(refills), 64'(0));
    check_val("hit_latency_le2", 64'(cycles <= 2), 64'(1));

    // Explicit flush from IDLE: one cycle to enter, then NUM_LINES walk cycles
    @(negedge clk);
    flush = 1'b1;
    wait_flush_done(n, seen, saw_ready, saw_req);
    flush = 1'b0;
    $display("flush: flush_done after %0d cycles", n);
    check_val("flush_done_seen", 64'(seen), 64'(1));
    check_val("flush_cycles", 64'(n), 64'(NUM_LINES + 1));

    // Spanning load refills both lines
    access(1'b0, 32'h103E, '0, '0, rd, refills, writes, cycles);
    check_val("span_refills", 64'(refills), 64'(2));
    check_val("span_refill0", 64'(refill_at(0)), 64'h1000);
    check_val("span_refill1", 64'(refill_at(1)), 64'h1040);
    check_val("span_rdata", 64'(rd), 64'h4140_3F3E);

    // Partial store hit, write-through, reload merged bytes
    access(1'b1, 32'h1004, 32'hAABB_CCDD, 4'b0101, rd, refills, writes, cycles);
    check_val("st_writes", 64'(writes), 64'(1));
    check_val("st_refills", 64'(refills), 64'(0));
    check_val("st_wr_be", 64'(wr_be_seen), 64'(4'b0101));
    check_val("st_wr_addr", 64'(wr_addr_seen), 64'h1004);
    check_val("st_wr_data", 64'(wr_data_seen), 64'hAABB_CCDD);
    access(1'b0, 32'h1004, '0, '0, rd, refills, writes, cycles);
    check_val("st_reload_rdata", 64'(rd), 64'h07BB_05DD);
    check_val("st_reload_refills", 64'(refills), 64'(0));

    // Conflict on the same index
    access(1'b0, 32'h5000, '0, '0, rd, refills, writes, cycles);
    check_val("conf_5000_refills", 64'(refills), 64'(1));
    check_val("conf_5000_addr", 64'(refill_at(0)), 64'h5000);
    check_val("conf_5000_rdata", 64'(rd), 64'h4342_4140);
    access(1'b0, 32'h1000, '0, '0, rd, refills, writes, cycles);
    check_val("conf_1000_refills", 64'(refills), 64'(1));
    check_val("conf_1000_rdata", 64'(rd), 64'h0302_0100);

    // Access wrapping the top of the address space
    access(1'b0, 32'hFFFF_FFFE, '0, '0, rd, refills, writes, cycles);
    check_val("wrap_refills", 64'(refills), 64'(2));
    check_val("wrap_refill0", 64'(refill_at(0)), 64'hFFFF_FFC0);
    check_val("wrap_refill1", 64'(refill_at(1)), 64'h0000_0000);
    check_val("wrap_rdata", 64'(rd), 64'hF1F0_5F5E);

    // Flush raised during REFILL: refill completes, walk runs, load re-misses
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2000;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (mem_req) seen = 1'b1;
    end
    check_val("fdr_mem_req", 64'(seen), 64'(1));
    check_val("fdr_mem_addr", 64'(mem_addr), 64'h2000);
    flush = 1'b1; mem_ack = 1'b1; mem_line = line_of(32'h2000);
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("fdr_mem_req_drop", 64'(mem_req), 64'(0));
    wait_flush_done(n, seen, saw_ready, saw_req);
    flush = 1'b0;
    $display("flush during refill: flush_done after %0d cycles", n);
    check_val("fdr_done_seen", 64'(seen), 64'(1));
    check_val("fdr_no_early_ready", 64'(saw_ready), 64'(0));
    run_access(rd, refills, writes, cycles);
    $display("LD addr=00002000 (after flush) -> rdata=%h refills=%0d", rd, refills);
    check_val("fdr_rerefills", 64'(refills), 64'(1));
    check_val("fdr_rdata", 64'(rd), 64'h1312_1110);
    access(1'b0, 32'h1000, '0, '0, rd, refills, writes, cycles);
    check_val("post_flush_1000_miss", 64'(refills), 64'(1));

    // Reset in the middle of REFILL; a late ack during the walk is ignored
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (mem_req) seen = 1'b1;
    end
    check_val("rmr_mem_req", 64'(seen), 64'(1));
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("reset mid-refill: mem_req=%b mem_addr=%h", mem_req, mem_addr);
    check_val("rmr_mem_req_low", 64'(mem_req), 64'(0));
    check_val("rmr_mem_addr_zero", 64'(mem_addr), 64'(0));
    check_val("rmr_cpu_ready_low", 64'(cpu_ready), 64'(0));
    repeat (10) @(negedge clk);
    mem_ack = 1'b1; mem_line = line_of(32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("rmr_late_ack_no_req", 64'(mem_req), 64'(0));
    wait_flush_done(n, seen, saw_ready, saw_req);
    check_val("rmr_done_seen", 64'(seen), 64'(1));
    access(1'b0, 32'h0000_0000, '0, '0, rd, refills, writes, cycles);
    check_val("late_ack_ignored_miss", 64'(refills), 64'(1));
    check_val("late_ack_rdata", 64'(rd), 64'hF3F2_F1F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
